// File: rtl/pattern_gen.sv
// pattern_gen: pseudo-random word source on a valid/ready stream for link self-test.
// A run of num_words Galois-LFSR words is emitted after start. A receiver seeded the
// same way regenerates the sequence and compares word by word.
//
// Optional feature macro: ERR_INJ_EN (adds err_inj input for one-shot bit-0 corruption).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin a run (sampled in IDLE/DONE only)
//   seed_load  load seed into LFSR (sampled in IDLE/DONE only)
//   seed       seed value; zero is replaced by 1
//   num_words  run length captured on start; 0 goes straight to DONE
//   data       current word (registered)
//   valid      word on data is valid (high in RUN)
//   ready      downstream accepts when valid && ready
//   busy       high in RUN
//   done       high in DONE
//   word_cnt   words accepted in current/last run
//   err_inj    (ERR_INJ_EN only) invert bit 0 of the word after the one accepted
module pattern_gen #(
  parameter int unsigned   N    = 16,
  parameter logic [N-1:0]  TAPS = 16'hB400,
  parameter logic [N-1:0]  SEED = 16'hACE1,
  parameter int unsigned   CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          seed_load,
  input  logic [N-1:0]  seed,
  input  logic [CW-1:0] num_words,
  output logic [N-1:0]  data,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_cnt
`ifdef ERR_INJ_EN
  ,
  input  logic          err_inj
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  lfsr_q, lfsr_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] num_q, num_d;
  logic [N-1:0]  seed_fix;
  logic [N-1:0]  lfsr_step;
  logic          accept;
  logic          flip_d;

  // An all-zero LFSR never leaves zero, so a zero seed is forced to 1.
  assign seed_fix  = (seed == '0) ? N'(1) : seed;
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign accept    = (state_q == StRun) && ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = (num_words == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (ready && ((cnt_q + CW'(1)) == num_q)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    num_d  = num_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (seed_load) begin
          lfsr_d = seed_fix;
        end
        if (start) begin
          num_d = num_words;
          cnt_d = '0;
        end
      end
      StRun: begin
        if (ready) begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef ERR_INJ_EN
  // The flip marks the presented word only; it is held with the word until it is
  // accepted and never feeds back into the LFSR.
  logic flip_q;

  always_comb begin
    flip_d = flip_q;
    if (accept) begin
      flip_d = err_inj;
    end else if ((state_q != StRun) && start) begin
      flip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flip_q <= 1'b0;
    end else begin
      flip_q <= flip_d;
    end
  end
`else
  assign flip_d = 1'b0;
`endif

  // data tracks the LFSR one register stage deep, so ready never reaches data
  // combinationally.
  assign data_d = lfsr_d ^ {{(N-1){1'b0}}, flip_d};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
      data_q <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
    end
  end

  // Outputs
  always_comb begin
    valid    = (state_q == StRun);
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    data     = data_q;
    word_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: behavioural model plus per-cycle compare,
// directed runs with hand-computed word lists, then randomized runs.
module tb_pattern_gen;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] num_words = '0;
  logic [15:0] data;
  logic        valid;
  logic        ready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;
  logic        err_inj = 1'b0;

  pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .num_words (num_words),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
`ifdef ERR_INJ_EN
    ,
    .err_inj   (err_inj)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  // Behavioural model: phase 0 idle, 1 run, 2 done.
  int          m_phase = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_cnt = 0;
  int          m_num = 0;
  bit          m_flip = 1'b0;
  bit          m_ok = 1'b0;
  logic [15:0] got_q[$];

  always @(posedge clk) begin
    if (rst_n && valid && ready) got_q.push_back(data);
    if (!rst_n) begin
      m_ok = 1'b1; m_phase = 0; m_lfsr = SEED; m_cnt = 0; m_flip = 1'b0;
    end else if (m_ok) begin
      if (m_phase == 1) begin
        if (ready) begin
`ifdef ERR_INJ_EN
          m_flip = err_inj;
`else
          m_flip = 1'b0;
`endif
          m_lfsr = step(m_lfsr);
          m_cnt++;
          if (m_cnt == m_num) m_phase = 2;
        end
      end else begin
        if (seed_load) m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
        if (start) begin
          m_num = int'(num_words); m_cnt = 0; m_flip = 1'b0;
          m_phase = (num_words == 16'h0) ? 2 : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid", {31'b0, valid}, {31'b0, m_phase == 1});
      chk("busy", {31'b0, busy}, {31'b0, m_phase == 1});
      chk("done", {31'b0, done}, {31'b0, m_phase == 2});
      chk("word_cnt", {16'b0, word_cnt}, 32'(m_cnt));
      if (m_phase == 1) chk("data", {16'b0, data}, {16'b0, m_lfsr ^ {15'b0, m_flip}});
    end
  end

  // Ready driver: 0 always ready, 1 repeating 1,0,0,1, 2 random (with random err_inj).
  int rdy_mode = 0;
  int rdy_ph = 0;
  bit rand_err = 1'b0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: ready = 1'b1;
      1: begin ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
      default: begin
        ready = 1'($urandom_range(0, 1));
        if (rand_err) err_inj = ($urandom_range(0, 3) == 0);
      end
    endcase
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_data", {16'b0, data}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic start_run(input bit sl, input logic [15:0] sv, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; seed_load = sl; seed = sv; num_words = n;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_timeout", {31'b0, done}, 32'h1);
  endtask

  task automatic chk_words(input string name, input logic [15:0] exp[$]);
    chk({name, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk(name, {16'b0, got_q[i]}, {16'b0, exp[i]});
  endtask

  // Hand-computed Galois steps from ACE1 and from 0001.
  logic [15:0] seq_ace1[$] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
  logic [15:0] seq_one[$]  = '{16'h0001, 16'hB400};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: four words, ready always high
    got_q.delete();
    rdy_mode = 0;
    start_run(1'b0, 16'h0, 16'd4);
    chk("t1_latency", {31'b0, valid}, 32'h1);
    wait_done(50);
    chk_words("t1_words", seq_ace1);
    chk("t1_cnt", {16'b0, word_cnt}, 32'd4);
    chk("t1_busy", {31'b0, busy}, 32'h0);

    // 2: ready stalls, same sequence after reseeding
    got_q.delete();
    rdy_mode = 1; rdy_ph = 0;
    start_run(1'b1, 16'hACE1, 16'd4);
    wait_done(50);
    chk_words("t2_words", seq_ace1);

    // 3: zero seed becomes 0001, then ACE1 reproduces the first run
    got_q.delete();
    rdy_mode = 0;
    start_run(1'b1, 16'h0000, 16'd2);
    wait_done(50);
    chk_words("t3_zero_seed", seq_one);
    got_q.delete();
    start_run(1'b1, 16'hACE1, 16'd4);
    wait_done(50);
    chk_words("t3_reseed", seq_ace1);

    // 4: empty run
    got_q.delete();
    start_run(1'b0, 16'h0, 16'd0);
    chk("t4_done", {31'b0, done}, 32'h1);
    chk("t4_cnt", {16'b0, word_cnt}, 32'h0);
    repeat (3) @(negedge clk);
    chk("t4_no_words", 32'(got_q.size()), 32'h0);

    // 5: reset after two of five words, restart from SEED
    got_q.delete();
    start_run(1'b0, 16'h0, 16'd5);
    for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge clk);
    do_reset();
    chk("t5_busy", {31'b0, busy}, 32'h0);
    chk("t5_done", {31'b0, done}, 32'h0);
    got_q.delete();
    start_run(1'b0, 16'h0, 16'd4);
    wait_done(50);
    chk_words("t5_restart", seq_ace1);

`ifdef ERR_INJ_EN
    // 6: corrupt the word after the first accepted one
    got_q.delete();
    start = 1'b1; num_words = 16'd3; seed_load = 1'b1; seed = 16'hACE1;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; err_inj = 1'b1;
    @(negedge clk);
    err_inj = 1'b0;
    wait_done(50);
    chk_words("t6_err_inj", '{16'hACE1, 16'hE271, 16'h7138});
`endif

    // Randomized runs against the model
    rdy_mode = 2;
`ifdef ERR_INJ_EN
    rand_err = 1'b1;
`endif
    for (int r = 0; r < 40; r++) begin
      start_run(1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                16'($urandom_range(0, 10)));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        do_reset();
      end else begin
        wait_done(200);
      end
    end
    rand_err = 1'b0;
    err_inj = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
